// File: rtl/lamp_conflict_monitor_if.sv
// Lamp bus between the traffic-light controller and the conflict monitor.
// The controller drives the lamp requests; the monitor drives the physical lamp pins and fault status.
interface lamp_conflict_monitor_if;
   logic       road_green_in;
   logic       road_yellow_in;
   logic       road_red_in;
   logic       ped_green_in;
   logic       ped_red_in;
   logic       clear_fault;
   logic       pin4_green;
   logic       pin5_yellow;
   logic       pin6_red;
   logic       pin7_ped_green;
   logic       pin8_ped_red;
   logic       fault;
   logic [2:0] fault_code;

   modport master (
      output road_green_in, road_yellow_in, road_red_in, ped_green_in, ped_red_in, clear_fault,
      input  pin4_green, pin5_yellow, pin6_red, pin7_ped_green, pin8_ped_red, fault, fault_code
   );

   modport slave (
      input  road_green_in, road_yellow_in, road_red_in, ped_green_in, ped_red_in, clear_fault,
      output pin4_green, pin5_yellow, pin6_red, pin7_ped_green, pin8_ped_red, fault, fault_code
   );
endinterface

// File: rtl/lamp_conflict_monitor.sv
// Independent lamp safety checker: registers controller requests, checks them, and either
// passes them to the lamp pins or latches a fault code and drives the flashing-yellow fail-safe.
module lamp_conflict_monitor #(
   parameter int unsigned TIMER_SCALE      = 16000000,
   parameter int unsigned MIN_YELLOW_TICKS = 80000000,
   parameter int unsigned DARK_TICKS       = 1600000
) (
   input  logic                  pin3_clk_16mhz,
   input  logic                  pin2_rst_n,
   lamp_conflict_monitor_if.slave lamp
);
   localparam int unsigned HALF_PERIOD = TIMER_SCALE / 2;
   localparam int FLASH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int DARK_W  = $clog2(DARK_TICKS + 1);
   localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(HALF_PERIOD - 1);
   localparam logic [DARK_W-1:0]  DARK_LAST  = DARK_W'(DARK_TICKS - 1);
   localparam logic [DARK_W-1:0]  DARK_MAX   = DARK_W'(DARK_TICKS);
   localparam logic [31:0]        MIN_YELLOW = 32'(MIN_YELLOW_TICKS);
   // Pin vector order: {ped_red, ped_green, road_red, road_yellow, road_green}
   localparam logic [4:0] PINS_RESET    = 5'b10000;
   localparam logic [4:0] PINS_FAILSAFE = 5'b10010;

   typedef enum logic [1:0] {ARMING, MONITOR, FAULT} state_t;
   typedef enum logic [1:0] {LAMP_NONE, LAMP_GREEN, LAMP_YELLOW, LAMP_RED} lamp_t;

   state_t               state_reg;
   lamp_t                last_lamp_reg;
   logic [4:0]           in_q;
   logic [4:0]           pins_reg;
   logic                 fault_reg;
   logic [2:0]           fault_code_reg;
   logic [DARK_W-1:0]    dark_cnt_reg;
   logic [31:0]          yellow_cnt_reg;
   logic [FLASH_W-1:0]   flash_cnt_reg;

   logic [DARK_W-1:0]    dark_cnt_next;
   logic [31:0]          yellow_cnt_next;
   logic [2:0]           road;
   logic [2:0]           road_pair;
   logic                 road_one_hot;
   logic                 road_dark;
   lamp_t                cur_lamp;
   lamp_t                succ_lamp;
   logic                 conflict, multi_road, ped_both, dark_viol, seq_viol, short_yellow;
   logic                 basic_viol;
   logic [2:0]           viol_code;

   assign road = in_q[2:0];

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_pair
         assign road_pair[gi] = road[gi] & road[(gi + 1) % 3];
      end
   endgenerate

   assign road_one_hot = (road == 3'b001) || (road == 3'b010) || (road == 3'b100);
   assign road_dark    = (road == 3'b000);

   always_comb begin
      cur_lamp = LAMP_NONE;
      case (road)
         3'b001:  cur_lamp = LAMP_GREEN;
         3'b010:  cur_lamp = LAMP_YELLOW;
         3'b100:  cur_lamp = LAMP_RED;
         default: cur_lamp = LAMP_NONE;
      endcase
   end

   always_comb begin
      succ_lamp = LAMP_NONE;
      case (last_lamp_reg)
         LAMP_GREEN:  succ_lamp = LAMP_YELLOW;
         LAMP_YELLOW: succ_lamp = LAMP_RED;
         LAMP_RED:    succ_lamp = LAMP_GREEN;
         default:     succ_lamp = LAMP_NONE;
      endcase
   end

   assign conflict     = in_q[3] & ~in_q[2];
   assign multi_road   = |road_pair;
   assign ped_both     = in_q[3] & in_q[4];
   assign dark_viol    = road_dark && (dark_cnt_reg >= DARK_LAST);
   // NONE accepts anything; re-lighting the remembered lamp after a gap is legal
   assign seq_viol     = road_one_hot && (last_lamp_reg != LAMP_NONE) &&
                         (cur_lamp != last_lamp_reg) && (cur_lamp != succ_lamp);
   // A non-zero yellow count on a red sample means yellow was lit on the previous sample
   assign short_yellow = (road == 3'b100) && (yellow_cnt_reg != 32'd0) &&
                         (yellow_cnt_reg < MIN_YELLOW);
   assign basic_viol   = conflict | multi_road | ped_both;

   always_comb begin
      viol_code = 3'd0;
      if (conflict)                                     viol_code = 3'd1;
      else if (multi_road)                              viol_code = 3'd2;
      else if (ped_both)                                viol_code = 3'd3;
      else if (dark_viol)                               viol_code = 3'd4;
      else if ((state_reg == MONITOR) && seq_viol)      viol_code = 3'd5;
      else if ((state_reg == MONITOR) && short_yellow)  viol_code = 3'd6;
   end

   assign dark_cnt_next   = !road_dark ? '0 :
                            (dark_cnt_reg == DARK_MAX) ? DARK_MAX : dark_cnt_reg + DARK_W'(1);
   assign yellow_cnt_next = !in_q[1] ? 32'd0 :
                            (&yellow_cnt_reg) ? yellow_cnt_reg : yellow_cnt_reg + 32'd1;

   always_ff @(posedge pin3_clk_16mhz or negedge pin2_rst_n) begin
      if (!pin2_rst_n) begin
         in_q           <= '0;
         state_reg      <= ARMING;
         last_lamp_reg  <= LAMP_NONE;
         pins_reg       <= PINS_RESET;
         fault_reg      <= 1'b0;
         fault_code_reg <= 3'd0;
         dark_cnt_reg   <= '0;
         yellow_cnt_reg <= 32'd0;
         flash_cnt_reg  <= '0;
      end else begin
         in_q           <= {lamp.ped_red_in, lamp.ped_green_in, lamp.road_red_in,
                            lamp.road_yellow_in, lamp.road_green_in};
         dark_cnt_reg   <= dark_cnt_next;
         yellow_cnt_reg <= yellow_cnt_next;
         if (road_one_hot) last_lamp_reg <= cur_lamp;

         case (state_reg)
            ARMING, MONITOR: begin
               if (viol_code != 3'd0) begin
                  state_reg      <= FAULT;
                  fault_reg      <= 1'b1;
                  fault_code_reg <= viol_code;
                  pins_reg       <= PINS_FAILSAFE;
                  flash_cnt_reg  <= '0;
               end else begin
                  pins_reg <= in_q;
                  if ((state_reg == ARMING) && road_one_hot) state_reg <= MONITOR;
               end
            end
            FAULT: begin
               if (lamp.clear_fault && !basic_viol) begin
                  state_reg      <= ARMING;
                  fault_reg      <= 1'b0;
                  fault_code_reg <= 3'd0;
                  pins_reg       <= in_q;
                  dark_cnt_reg   <= '0;
                  yellow_cnt_reg <= 32'd0;
                  flash_cnt_reg  <= '0;
                  last_lamp_reg  <= LAMP_NONE;
               end else if (flash_cnt_reg == FLASH_LAST) begin
                  flash_cnt_reg <= '0;
                  pins_reg[1]   <= ~pins_reg[1];
               end else begin
                  flash_cnt_reg <= flash_cnt_reg + FLASH_W'(1);
               end
            end
            default: state_reg <= ARMING;
         endcase
      end
   end

   assign lamp.pin4_green     = pins_reg[0];
   assign lamp.pin5_yellow    = pins_reg[1];
   assign lamp.pin6_red       = pins_reg[2];
   assign lamp.pin7_ped_green = pins_reg[3];
   assign lamp.pin8_ped_red   = pins_reg[4];
   assign lamp.fault          = fault_reg;
   assign lamp.fault_code     = fault_code_reg;
endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Bench for lamp_conflict_monitor: directed scenarios plus random lamp traffic, all checked
// every cycle against a history-based model of the safety rules.
module tb_lamp_conflict_monitor;
   localparam int TS = 8, MINY = 20, DARK = 4, HALF = TS / 2;
   // {ped_red, ped_green, road_red, road_yellow, road_green}
   localparam logic [4:0] V_G = 5'b10001, V_Y = 5'b10010, V_R = 5'b10100;
   localparam logic [4:0] V_RPED = 5'b01100, V_DARK = 5'b10000, V_CONF = 5'b01001;

   logic pin3_clk_16mhz = 1'b0;
   logic pin2_rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   lamp_conflict_monitor_if lif();

   lamp_conflict_monitor #(
      .TIMER_SCALE(TS), .MIN_YELLOW_TICKS(MINY), .DARK_TICKS(DARK)
   ) dut (
      .pin3_clk_16mhz(pin3_clk_16mhz),
      .pin2_rst_n(pin2_rst_n),
      .lamp(lif)
   );

   always #31 pin3_clk_16mhz = ~pin3_clk_16mhz;

   // Model state: samples seen since the last arming point, plus the fault bookkeeping
   logic [4:0] hist[$];
   logic [4:0] inq_m = 5'b0;
   bit         m_fault = 0;
   int         m_code = 0;
   int         m_age = 0;
   logic [4:0] exp_pins = 5'b10000;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int road_id(input logic [4:0] v);
      case (v[2:0])
         3'b001:  return 1;
         3'b010:  return 2;
         3'b100:  return 3;
         default: return 0;
      endcase
   endfunction

   function automatic int basic_code(input logic [4:0] s);
      if (s[3] && !s[2]) return 1;
      if ((int'(s[0]) + int'(s[1]) + int'(s[2])) >= 2) return 2;
      if (s[3] && s[4]) return 3;
      return 0;
   endfunction

   task automatic model_edge(input logic clr);
      logic [4:0] s;
      int code, last, dark_run, y_run, id;
      bit armed;
      s = inq_m;
      if (m_fault) begin
         if (clr && basic_code(s) == 0) begin
            m_fault = 0; m_code = 0; exp_pins = s;
            hist.delete();
         end else begin
            m_age++;
            exp_pins = {1'b1, 1'b0, 1'b0, ((m_age / HALF) % 2 == 0), 1'b0};
         end
      end else begin
         last = 0; armed = 0; dark_run = 0; y_run = 0;
         for (int i = hist.size() - 1; i >= 0; i--)
            if (road_id(hist[i]) != 0) begin last = road_id(hist[i]); armed = 1; break; end
         for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i][2:0] == 3'b000) dark_run++; else break;
         for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i][1]) y_run++; else break;
         code = basic_code(s);
         id = road_id(s);
         if (code == 0 && s[2:0] == 3'b000 && dark_run + 1 >= DARK) code = 4;
         if (code == 0 && armed && id != 0 && id != last && id != (last % 3) + 1) code = 5;
         if (code == 0 && armed && id == 3 && y_run > 0 && y_run < MINY) code = 6;
         if (code != 0) begin
            m_fault = 1; m_code = code; m_age = 0; exp_pins = 5'b10010;
         end else begin
            exp_pins = s;
         end
         hist.push_back(s);
      end
   endtask

   function automatic logic [4:0] dut_pins();
      return {lif.pin8_ped_red, lif.pin7_ped_green, lif.pin6_red, lif.pin5_yellow, lif.pin4_green};
   endfunction

   // Called at a negative edge: drive, let one active edge pass, compare, return at next negedge
   task automatic tick(input logic [4:0] v, input logic clr);
      {lif.ped_red_in, lif.ped_green_in, lif.road_red_in, lif.road_yellow_in, lif.road_green_in} = v;
      lif.clear_fault = clr;
      @(posedge pin3_clk_16mhz);
      #1;
      model_edge(clr);
      inq_m = v;
      check_value("pins", 32'(dut_pins()), 32'(exp_pins));
      check_value("fault", 32'(lif.fault), 32'(m_fault));
      check_value("fault_code", 32'(lif.fault_code), 32'(m_code));
      @(negedge pin3_clk_16mhz);
   endtask

   task automatic hold(input logic [4:0] v, input int n, input string name);
      $display("seg %-10s value=%b ticks=%0d fault=%0d code=%0d", name, v, n, m_fault, m_code);
      for (int i = 0; i < n; i++) tick(v, 1'b0);
   endtask

   task automatic rearm();
      $display("seg rearm      clear with clean red");
      tick(V_R, 1'b0);
      tick(V_R, 1'b1);
   endtask

   task automatic do_reset();
      #2 pin2_rst_n = 1'b0;
      #1;
      check_value("rst_pins", 32'(dut_pins()), 32'd16);
      check_value("rst_fault", 32'(lif.fault), 32'd0);
      check_value("rst_code", 32'(lif.fault_code), 32'd0);
      {lif.ped_red_in, lif.ped_green_in, lif.road_red_in, lif.road_yellow_in, lif.road_green_in} = 5'b0;
      lif.clear_fault = 1'b0;
      repeat (2) @(posedge pin3_clk_16mhz);
      @(negedge pin3_clk_16mhz);
      pin2_rst_n = 1'b1;
      hist.delete();
      inq_m = 5'b0; m_fault = 0; m_code = 0; m_age = 0; exp_pins = 5'b10000;
      $display("seg reset      released");
   endtask

   initial begin
      #10ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cur;
      int r;
      logic [4:0] rv;
      {lif.ped_red_in, lif.ped_green_in, lif.road_red_in, lif.road_yellow_in, lif.road_green_in} = 5'b0;
      lif.clear_fault = 1'b0;
      @(negedge pin3_clk_16mhz);
      do_reset();

      // Legal cycle twice
      for (int k = 0; k < 2; k++) begin
         hold(V_G, 30, "green");
         hold(V_Y, 25, "yellow");
         hold(V_R, 10, "red");
         hold(V_RPED, 10, "red+ped");
         hold(V_R, 10, "red");
      end
      hold(V_G, 5, "green");
      check_value("legal_fault", 32'(lif.fault), 32'd0);

      // Ped green against road green, fail-safe flashing
      hold(V_CONF, 2, "conflict");
      check_value("conflict_fault", 32'(lif.fault), 32'd1);
      check_value("conflict_code", 32'(lif.fault_code), 32'd1);
      check_value("failsafe_ped_red", 32'(lif.pin8_ped_red), 32'd1);
      check_value("failsafe_ped_green", 32'(lif.pin7_ped_green), 32'd0);
      check_value("flash_0", 32'(lif.pin5_yellow), 32'd1);
      for (int i = 1; i < 8; i++) begin
         tick(V_CONF, 1'b0);
         check_value($sformatf("flash_%0d", i), 32'(lif.pin5_yellow), (i < 4) ? 32'd1 : 32'd0);
      end

      // Clear refused while conflict is present, then accepted on clean red
      $display("seg clear      during conflict");
      tick(V_CONF, 1'b1);
      check_value("clear_refused", 32'(lif.fault), 32'd1);
      $display("seg clear      on clean red, next lamp yellow");
      tick(V_R, 1'b0);
      tick(V_Y, 1'b1);
      tick(V_Y, 1'b0);
      check_value("cleared_fault", 32'(lif.fault), 32'd0);
      check_value("cleared_code", 32'(lif.fault_code), 32'd0);
      hold(V_Y, 20, "yellow");
      hold(V_R, 3, "red");
      check_value("arm_yellow_ok", 32'(lif.fault), 32'd0);

      // Short yellow, then long enough yellow
      hold(V_G, 5, "green");
      hold(V_Y, 12, "yellow12");
      hold(V_R, 2, "red");
      check_value("short_yellow", 32'(lif.fault_code), 32'd6);
      rearm();
      hold(V_G, 5, "green");
      hold(V_Y, 20, "yellow20");
      hold(V_R, 3, "red");
      check_value("yellow20_ok", 32'(lif.fault), 32'd0);

      // Green straight to red
      hold(V_G, 5, "green");
      hold(V_R, 2, "red");
      check_value("sequence", 32'(lif.fault_code), 32'd5);
      rearm();

      // Dark heads
      hold(V_G, 5, "green");
      hold(V_DARK, 5, "dark4");
      check_value("dark", 32'(lif.fault_code), 32'd4);
      rearm();
      hold(V_G, 5, "green");
      hold(V_DARK, 3, "dark3");
      hold(V_G, 4, "green");
      check_value("dark3_ok", 32'(lif.fault), 32'd0);

      // Codes 1 and 2 together: lowest wins
      hold(5'b01011, 2, "conf+multi");
      check_value("priority", 32'(lif.fault_code), 32'd1);

      // Reset while faulted
      do_reset();

      // Random traffic
      cur = 3;
      for (int seg = 0; seg < 80; seg++) begin
         r = $urandom_range(0, 11);
         if (m_fault && r < 4) begin
            rearm();
            cur = 3;
         end
         case (r)
            0: begin
               rv = 5'($urandom_range(0, 31));
               hold(rv, 1, "random");
            end
            1: hold(V_DARK, $urandom_range(1, 5), "dark");
            2: begin
               cur = $urandom_range(1, 3);
               hold((cur == 1) ? V_G : (cur == 2) ? V_Y : V_R, $urandom_range(1, 10), "jump");
            end
            3: begin
               $display("seg clear      pulse on lamp %0d", cur);
               tick((cur == 1) ? V_G : (cur == 2) ? V_Y : V_R, 1'b1);
            end
            default: begin
               cur = cur % 3 + 1;
               if (cur == 1) hold(V_G, $urandom_range(3, 20), "green");
               else if (cur == 2) hold(V_Y, $urandom_range(12, 26), "yellow");
               else begin
                  hold(V_R, $urandom_range(1, 5), "red");
                  if ($urandom_range(0, 1) == 1) hold(V_RPED, $urandom_range(1, 8), "red+ped");
                  hold(V_R, $urandom_range(1, 5), "red");
               end
            end
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/lamp_conflict_monitor.md
Name: lamp_conflict_monitor

Overview:
- Independent safety checker on the reader side of the lamp interface.
- Sits between the traffic-light controller's five lamp signals and the physical lamp pins.
- Checks every sample for illegal combinations, road-sequence order, minimum yellow time and dark road heads.
- On the first violation it latches a fault code and forces the fail-safe pattern: road yellow flashing at 1 Hz, ped red on, all else off.

Parameters:
TIMER_SCALE, 16000000, clock ticks per second; flash half-period = TIMER_SCALE/2 ticks.
MIN_YELLOW_TICKS, 80000000, minimum continuous yellow ticks before red is allowed.
DARK_TICKS, 1600000, maximum consecutive ticks with no road lamp lit.

Ports:
pin3_clk_16mhz  in  1  system clock
pin2_rst_n  in  1  asynchronous active-low reset
road_green_in  in  1  controller road green request
road_yellow_in  in  1  controller road yellow request
road_red_in  in  1  controller road red request
ped_green_in  in  1  controller ped green request
ped_red_in  in  1  controller ped red request
clear_fault  in  1  synchronous single-cycle fault clear
pin4_green  out  1  road green lamp
pin5_yellow  out  1  road yellow lamp
pin6_red  out  1  road red lamp
pin7_ped_green  out  1  ped green lamp
pin8_ped_red  out  1  ped red lamp
fault  out  1  sticky fault flag
fault_code  out  3  first fault cause, 0 = none

Behaviour:
- One clock, pin3_clk_16mhz. Reset pin2_rst_n is asynchronous, active-low; all flops clear on its assertion.
- Reset values:
  - Lamp outputs 0, except pin8_ped_red = 1.
  - fault = 0, fault_code = 0.
  - State ARMING, last-road-lamp = NONE.
  - Dark, yellow and flash counters = 0.
- Pipeline:
  - Stage 1 registers the five inputs (in_q).
  - Checks evaluate in_q; lamp outputs, fault and fault_code register from the check result.
  - Input to lamp pin latency is 2 cycles.
  - A violation present at edge N gives fault = 1 after edge N+1. The lamp pins switch to fail-safe on that same edge.
- Checks on in_q. If several fire in one cycle, the lowest code wins:
  - 1 CONFLICT: ped_green and not road_red.
  - 2 MULTI_ROAD: two or more road lamps lit.
  - 3 PED_BOTH: ped_green and ped_red both lit.
  - 4 DARK: no road lamp lit for DARK_TICKS consecutive ticks. The dark counter counts while dark, resets to 0 when any road lamp is lit, and saturates.
  - 5 SEQUENCE: a single road lamp becomes lit that differs from last-road-lamp and is not its legal successor (G→Y, Y→R, R→G). NONE accepts any lamp. Relighting the same lamp after a dark gap is legal.
  - 6 SHORT_YELLOW: red becomes lit directly after yellow while the yellow counter is below MIN_YELLOW_TICKS. The yellow counter is 32 bits, counts while yellow is lit, saturates at all-ones, and resets when yellow goes off.
- last-road-lamp updates only on samples with exactly one road lamp lit.
- States:
  - ARMING: after reset or clear. Active checks are codes 1, 2, 3 and 4. Moves to MONITOR on the first sample with exactly one road lamp lit; that lamp becomes last-road-lamp.
  - MONITOR: all checks active. Lamp pins = in_q.
  - FAULT: fault = 1 and fault_code is frozen. Later violations do not overwrite it.
    - Fail-safe pins: green 0, red 0, ped green 0, ped red 1.
    - Yellow toggles every TIMER_SCALE/2 ticks. The flash counter starts at 0 on FAULT entry, and yellow starts at 1.
- Clear:
  - In FAULT, clear_fault = 1 while in_q shows no code 1–3 violation gives ARMING on the next edge. fault and fault_code go to 0, counters clear, last-road-lamp = NONE.
  - If a code 1–3 violation is present, the clear is ignored.
  - clear_fault outside FAULT has no effect.
- Reset mid-fault returns immediately to the reset values above.

Test Plan (TIMER_SCALE=8, MIN_YELLOW_TICKS=20, DARK_TICKS=4):
- Legal cycle: G 30 ticks → Y 25 → R 30 → ped green 10 within red → G, repeated twice → fault stays 0; pins equal inputs delayed 2 cycles.
- ped_green_in=1 with road_green_in=1 at edge N → fault=1 and fault_code=1 after edge N+1; pin5_yellow pattern 1,1,1,1,0,0,0,0…; pin8_ped_red=1; pin7_ped_green=0.
- Yellow held 12 ticks then red → fault_code=6. Repeat with yellow held 20 ticks → no fault.
- G then directly R → fault_code=5. All road lamps off 4 ticks → fault_code=4. Off 3 ticks then the same lamp relit → no fault.
- Faults latched; clear_fault pulsed while ped_green and road_green are both high → still faulted. Pulsed with a clean red → fault=0, fault_code=0, ARMING; next lamp Y accepted.
- Simultaneous codes 1 and 2 in one sample → fault_code=1. pin2_rst_n low mid-fault → all lamp pins 0, pin8_ped_red=1, fault=0 asynchronously.
